cache_ctrl_wb_dm: RTL and testbench
===================================

# cache_ctrl_wb_dm

Clocked controller for the write-back, direct-mapped cache: owns the tag/valid/dirty state and the line data storage, and accepts one CPU word request at a time. On a miss it sequences the word-serial main-memory port: first it writes back a dirty victim line, then it refills the line. It sits between the CPU-side request port and the main memory model, replacing the combinational cache path with a handshaked, multi-cycle one.

## Interface
Parameters:
- ADDR_W, 10, byte address width
- DATA_W, 32, word width
- LINES, 4, number of cache lines (index = address[5:4])
- WORDS, 4, words per line (offset = address[3:2]); address[1:0] ignored; tag = address[9:6]

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  request valid; held with stable fields until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  10  byte address
- cpu_wdata  in  32  write data
- cpu_ready  out  1  one-cycle response strobe
- cpu_hit  out  1  1 if the request hit at first lookup; valid with cpu_ready
- cpu_rdata  out  32  read data; registered, held until next response
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = writeback beat, 0 = refill beat
- mem_addr  out  10  word-aligned byte address of current beat
- mem_wdata  out  32  writeback data for current beat
- mem_rdata  in  32  refill data, valid with mem_ack
- mem_ack  in  1  completes current beat (any latency ≥ 1 cycle)

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, DONE.
- IDLE: if cpu_req, latch we/addr/wdata into request registers, clear miss flag, go to COMPARE.
- COMPARE: hit = valid[idx] && tag[idx]==req_tag.
  - Hit and read: cpu_rdata <= line[idx][off].
  - Hit and write: line[idx][off] <= req_wdata and dirty[idx] <= 1. Memory is not written.
  - On a hit, set cpu_hit <= !miss_flag, then go to DONE.
  - Miss: set miss_flag, clear beat counter. If valid && dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={tag[idx], idx, beat, 2'b00}, mem_wdata=line[idx][beat]. On mem_ack, beat++. On the ack of beat 3, clear dirty[idx], reset beat, and go to ALLOCATE.
- ALLOCATE: mem_req=1, mem_we=0, mem_addr={req_tag, idx, beat, 2'b00}. On mem_ack, line[idx][beat] <= mem_rdata and beat++. On the ack of beat 3, set valid[idx]=1, tag[idx]=req_tag, dirty[idx]=0, and go to COMPARE. The second lookup always hits, so write misses are write-allocate.
- DONE: cpu_ready=1 for this cycle only, then go to IDLE. cpu_req seen in the following IDLE cycle is a new request.
- Beat counter is 2 bits; it wraps 3→0 only on the final ack.
- mem_addr and mem_we change only after an ack or a state change. mem_req stays high across consecutive beats and between WRITEBACK and ALLOCATE.
- mem_ack outside WRITEBACK/ALLOCATE is ignored.
- cpu_req changes while the controller is busy are ignored; the request registers are authoritative.

## Timing
- Reset, at the edge where reset=1:
  - state=IDLE, beat=0, all valid and dirty bits 0, miss_flag=0.
  - cpu_ready=0, cpu_hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Data and tag arrays are not cleared.
- Reset mid-transfer abandons the operation: mem_req is low from the next cycle, no response is issued, and the partial line stays invalid.
- Hit latency: request accepted at edge 0, COMPARE in cycle 1, cpu_ready in cycle 2.
- Clean miss, memory acks one cycle after each mem_req beat: ALLOCATE in cycles 2–5, COMPARE in cycle 6, cpu_ready in cycle 7.
- Dirty miss with the same memory timing: cpu_ready in cycle 11.
- Each additional memory wait cycle adds one cycle per beat.
- Outputs are Moore outputs of the state and registers; there is no combinational path from cpu_* to cpu_ready.

## Test plan
Memory model preloaded with word@0x000=0x00003cc3, word@0x200=0x00000ccc, word@0x300=0x000000c3.
- Read 0x000 after reset -> 4 refill beats at 0x000/0x004/0x008/0x00C; then cpu_ready with cpu_hit=0, cpu_rdata=0x00003cc3, in cycle 7 with 1-cycle ack.
- Write 0x000 data 0x000000ff -> cpu_hit=1 in cycle 2 and no mem_req; memory word 0 remains 0x00003cc3. Then read 0x000 -> hit, 0x000000ff.
- Read 0x200 (dirty conflict) -> 4 writeback beats at 0x000–0x00C, after which memory word 0=0x000000ff; then refill from 0x200; cpu_hit=0, rdata=0x00000ccc, ready in cycle 11.
- Read 0x000, then 0x300, then 0x200 -> each is a clean miss with no writeback beats; rdata 0x000000ff, 0x000000c3, 0x00000ccc.
- Memory acks after a random 1–5 cycle delay, and cpu_req toggles while busy -> results match the in-order model; mem_addr stays stable within each beat.
- Assert reset during writeback beat 2 -> mem_req=0 and all outputs 0 on the next cycle. A subsequent read of 0x000 misses and refills with no writeback.

Source files
------------

// File: rtl/cache_ctrl_wb_dm.sv
// Write-back, direct-mapped cache controller: owns tag/valid/dirty state and line
// storage, serves one CPU word request at a time over a word-serial memory port.
module cache_ctrl_wb_dm #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 4,
  parameter int unsigned WORDS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    DONE
  } ctrlState;

  ctrlState state, stateNext;

  logic              reqWe;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              missFlag;
  logic [OFF_W-1:0]  beat, beatNext;

  logic [LINES-1:0]  validBits;
  logic [LINES-1:0]  dirtyBits;
  logic [TAG_W-1:0]  tagArr   [LINES];
  logic [DATA_W-1:0] lineData [LINES][WORDS];

  logic [IDX_W-1:0]  reqIdx;
  logic [OFF_W-1:0]  reqOff;
  logic [TAG_W-1:0]  reqTag;
  logic              lineHit;
  logic              lastAck;
  logic              unusedReqBits;

  assign reqIdx        = reqAddr[OFF_W+2 +: IDX_W];
  assign reqOff        = reqAddr[2 +: OFF_W];
  assign reqTag        = reqAddr[ADDR_W-1 -: TAG_W];
  assign lineHit       = validBits[reqIdx] && (tagArr[reqIdx] == reqTag);
  assign lastAck       = mem_ack && (beat == LAST_BEAT);
  assign unusedReqBits = ^reqAddr[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and beat sequencing
  always_comb begin
    stateNext = state;
    beatNext  = beat;
    case (state)
      IDLE: begin
        if (cpu_req) stateNext = COMPARE;
      end
      COMPARE: begin
        if (lineHit) begin
          stateNext = DONE;
        end else begin
          beatNext  = '0;
          stateNext = (validBits[reqIdx] && dirtyBits[reqIdx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          beatNext = beat + OFF_W'(1);
          if (beat == LAST_BEAT) stateNext = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_ack) begin
          beatNext = beat + OFF_W'(1);
          if (beat == LAST_BEAT) stateNext = COMPARE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request registers, line status bits and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      reqWe     <= 1'b0;
      reqAddr   <= '0;
      reqWdata  <= '0;
      missFlag  <= 1'b0;
      beat      <= '0;
      validBits <= '0;
      dirtyBits <= '0;
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      beat <= beatNext;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            reqWe    <= cpu_we;
            reqAddr  <= cpu_addr;
            reqWdata <= cpu_wdata;
            missFlag <= 1'b0;
          end
        end
        COMPARE: begin
          if (lineHit) begin
            if (reqWe) dirtyBits[reqIdx] <= 1'b1;
            else       cpu_rdata <= lineData[reqIdx][reqOff];
            cpu_hit <= !missFlag;
          end else begin
            missFlag <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (lastAck) dirtyBits[reqIdx] <= 1'b0;
        end
        ALLOCATE: begin
          if (lastAck) begin
            validBits[reqIdx] <= 1'b1;
            dirtyBits[reqIdx] <= 1'b0;
          end
        end
        default: ;
      endcase

      // Memory beat fields follow the upcoming state/beat so they move only on ack or state change
      cpu_ready <= (stateNext == DONE);
      mem_req   <= (stateNext == WRITEBACK) || (stateNext == ALLOCATE);
      mem_we    <= (stateNext == WRITEBACK);
      if (stateNext == WRITEBACK) begin
        mem_addr  <= {tagArr[reqIdx], reqIdx, beatNext, 2'b00};
        mem_wdata <= lineData[reqIdx][beatNext];
      end else if (stateNext == ALLOCATE) begin
        mem_addr  <= {reqTag, reqIdx, beatNext, 2'b00};
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies their contents
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == COMPARE && lineHit && reqWe)
        lineData[reqIdx][reqOff] <= reqWdata;
      if (state == ALLOCATE && mem_ack) begin
        lineData[reqIdx][beat] <= mem_rdata;
        if (beat == LAST_BEAT) tagArr[reqIdx] <= reqTag;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl_wb_dm.sv
// Scoreboard bench for cache_ctrl_wb_dm: a word-serial memory model with fixed or
// random ack delay, expected memory beats and CPU responses queued by the stimulus.
module tb_cache_ctrl_wb_dm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic        cpu_hit;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  cache_ctrl_wb_dm dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_hit   (cpu_hit),
    .cpu_rdata (cpu_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        chkRd;
    logic [31:0] rd;
    int          lat;
    int          acc;
  } respT;

  respT        scoreQ[$];
  logic [10:0] expBeatQ[$];
  logic [31:0] memory [256];
  int          nChecks = 0;
  int          nFails = 0;
  int          cycleCnt = 0;
  int          ackCount = 0;
  logic        randMode = 1'b0;
  logic        toggleReq = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endfunction

  always @(posedge clk) cycleCnt++;

  // Memory model: beat starts when mem_req is seen, acked after 1 (or 1-5) cycles
  logic       inBeat = 1'b0;
  logic [9:0] beatAddr = '0;
  int         waitLeft = 0;
  always @(negedge clk) begin
    logic [10:0] e;
    if (reset || !mem_req) begin
      mem_ack = 1'b0;
      inBeat  = 1'b0;
    end else begin
      if (!inBeat) begin
        inBeat   = 1'b1;
        beatAddr = mem_addr;
        waitLeft = randMode ? int'($urandom_range(5, 1)) - 1 : 0;
      end
      if (waitLeft == 0) begin
        check("beatAddrStable", 32'(mem_addr), 32'(beatAddr));
        if (expBeatQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpectedBeat: got we=%0b addr=0x%03h, expected no beat", mem_we, mem_addr);
        end else begin
          e = expBeatQ.pop_front();
          check("beatWe", 32'(mem_we), 32'(e[10]));
          check("beatAddr", 32'(mem_addr), 32'(e[9:0]));
        end
        if (mem_we) memory[mem_addr[9:2]] = mem_wdata;
        else        mem_rdata = memory[mem_addr[9:2]];
        mem_ack = 1'b1;
        inBeat  = 1'b0;
        ackCount++;
      end else begin
        mem_ack = 1'b0;
        waitLeft--;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    respT r;
    if (!reset && cpu_ready) begin
      if (scoreQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpectedResponse: got hit=%0b rdata=0x%08h, expected none", cpu_hit, cpu_rdata);
      end else begin
        r = scoreQ.pop_front();
        check("respHit", 32'(cpu_hit), 32'(r.hit));
        if (r.chkRd) check("respRdata", cpu_rdata, r.rd);
        if (r.lat != 0) check("respLatency", 32'(cycleCnt - r.acc + 1), 32'(r.lat));
      end
    end
  end

  task automatic pushBeats(input logic we, input logic [9:0] base);
    for (int i = 0; i < 4; i++) expBeatQ.push_back({we, base + 10'(4 * i)});
  endtask

  task automatic doReq(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                       input logic expHit, input logic chkRd, input logic [31:0] expRd,
                       input int expLat);
    respT r;
    int   waited;
    logic got;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
    r.hit   = expHit;
    r.chkRd = chkRd;
    r.rd    = expRd;
    r.lat   = expLat;
    r.acc   = cycleCnt + 1;
    scoreQ.push_back(r);
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 300) begin
      @(negedge clk);
      if (cpu_ready) got = 1'b1;
      else begin
        waited++;
        if (toggleReq && cycleCnt >= r.acc) cpu_req = 1'($urandom_range(1, 0));
      end
    end
    if (!got) begin
      nChecks++;
      nFails++;
      $display("FAIL reqTimeout: got no cpu_ready for addr 0x%03h, expected one", addr);
      scoreQ.delete();
      expBeatQ.delete();
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
    check({tag, "_cpu_hit"},   32'(cpu_hit),   32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata,      32'd0);
    check({tag, "_mem_req"},   32'(mem_req),   32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
  endtask

  initial begin
    int waited;
    int base;
    for (int i = 0; i < 256; i++) memory[i] = '0;
    memory[10'h000 >> 2] = 32'h0000_3cc3;
    memory[10'h200 >> 2] = 32'h0000_0ccc;
    memory[10'h300 >> 2] = 32'h0000_00c3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed, one-cycle memory acks
    pushBeats(1'b0, 10'h000);
    doReq(1'b0, 10'h000, 32'h0, 1'b0, 1'b1, 32'h0000_3cc3, 7);
    doReq(1'b1, 10'h000, 32'h0000_00ff, 1'b1, 1'b0, 32'h0, 2);
    check("memWord0AfterHitWrite", memory[0], 32'h0000_3cc3);
    doReq(1'b0, 10'h000, 32'h0, 1'b1, 1'b1, 32'h0000_00ff, 2);
    pushBeats(1'b1, 10'h000);
    pushBeats(1'b0, 10'h200);
    doReq(1'b0, 10'h200, 32'h0, 1'b0, 1'b1, 32'h0000_0ccc, 11);
    check("memWord0AfterWriteback", memory[0], 32'h0000_00ff);
    pushBeats(1'b0, 10'h000);
    doReq(1'b0, 10'h000, 32'h0, 1'b0, 1'b1, 32'h0000_00ff, 7);
    pushBeats(1'b0, 10'h300);
    doReq(1'b0, 10'h300, 32'h0, 1'b0, 1'b1, 32'h0000_00c3, 7);
    pushBeats(1'b0, 10'h200);
    doReq(1'b0, 10'h200, 32'h0, 1'b0, 1'b1, 32'h0000_0ccc, 7);

    // Random memory latency with cpu_req toggling while busy
    randMode  = 1'b1;
    toggleReq = 1'b1;
    pushBeats(1'b0, 10'h010);
    doReq(1'b1, 10'h014, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 0);
    doReq(1'b0, 10'h014, 32'h0, 1'b1, 1'b1, 32'h1111_1111, 0);
    doReq(1'b0, 10'h010, 32'h0, 1'b1, 1'b1, 32'h0, 0);
    pushBeats(1'b1, 10'h010);
    pushBeats(1'b0, 10'h210);
    doReq(1'b0, 10'h214, 32'h0, 1'b0, 1'b1, 32'h0, 0);
    check("memWord014AfterWriteback", memory[10'h014 >> 2], 32'h1111_1111);
    pushBeats(1'b0, 10'h010);
    doReq(1'b0, 10'h014, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 0);
    doReq(1'b1, 10'h208, 32'h2222_2222, 1'b1, 1'b0, 32'h0, 0);

    // Reset during writeback beat 2 of a dirty conflict
    randMode  = 1'b0;
    toggleReq = 1'b0;
    expBeatQ.push_back({1'b1, 10'h200});
    expBeatQ.push_back({1'b1, 10'h204});
    base     = ackCount;
    cpu_we   = 1'b0;
    cpu_addr = 10'h000;
    cpu_req  = 1'b1;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    waited  = 0;
    while (ackCount < base + 2 && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (ackCount < base + 2) begin
      nChecks++;
      nFails++;
      $display("FAIL wbTimeout: got %0d acks, expected 2", ackCount - base);
    end
    @(posedge clk);
    #1;
    check("wbBeat2Addr", 32'(mem_addr), 32'h208);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("midReset");
    reset = 1'b0;
    check("beatsPendingAfterReset", 32'(expBeatQ.size()), 32'd0);
    check("memWord208NotWritten", memory[10'h208 >> 2], 32'h0);

    pushBeats(1'b0, 10'h000);
    doReq(1'b0, 10'h000, 32'h0, 1'b0, 1'b1, 32'h0000_00ff, 7);

    repeat (3) @(posedge clk);
    check("scoreQEmpty", 32'(scoreQ.size()), 32'd0);
    check("beatQEmpty", 32'(expBeatQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
